dvi_frame_packer: RTL

- Upstream neighbour of the EL output stage.
- Samples the decoded DVI pixel stream (DE/HSYNC/VSYNC plus 8-bit luma), thresholds each pixel to 1 bit and packs 8 pixels per byte, MSB = leftmost.
- Decimates source lines vertically and writes the result into the shared 15-bit-addressed frame RAM. The output stage reads that RAM at address x + y*SCREEN_WIDTH.
- Frame RAM layout is byte-row-major: 80 bytes/line × 240 lines = 19200 bytes.

---
 rtl/dvi_el_pkg.sv | 18 +
 rtl/dvi_frame_packer_if.sv | 12 +
 rtl/pix_packer_8.sv | 49 ++++
 rtl/dvi_frame_packer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dvi_el_pkg.sv
// Shared constants and FSM encoding for the DVI capture / EL output path.
package dvi_el_pkg;

    localparam int unsigned SCREEN_WIDTH_DEF  = 80;
    localparam int unsigned SCREEN_HEIGHT_DEF = 240;
    localparam int unsigned ADDR_W            = 15;
    localparam int unsigned BYTE_W            = 8;

    typedef enum logic [2:0] {
        WAIT_VS   = 3'd0,
        WAIT_LINE = 3'd1,
        IN_LINE   = 3'd2,
        FLUSH     = 3'd3,
        SKIP_LINE = 3'd4,
        LINE_END  = 3'd5
    } fsmState_t;

endpackage

// File: rtl/dvi_frame_packer_if.sv
// Frame RAM write port: one strobe, byte address and data per cycle.
interface dvi_frame_packer_if;
    import dvi_el_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BYTE_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/pix_packer_8.sv
// Thresholds luma to 1 bit and packs 8 pixels per byte, leftmost pixel in the MSB.
module pix_packer_8
    import dvi_el_pkg::*;
#(
    parameter int unsigned THRESHOLD = 128
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              sampleEn,
    input  logic              flush,
    input  logic              clear,
    input  logic [BYTE_W-1:0] lumaIn,
    output logic              byteValid_c,
    output logic [BYTE_W-1:0] pixByte_c,
    output logic              pending_c
);

    logic [BYTE_W-1:0] shreg;
    logic [2:0]        bitCnt;
    logic              litBit;

    // Pixel is lit at or above the threshold.
    assign litBit    = (32'(lumaIn) >= THRESHOLD);
    assign pending_c = (bitCnt != 3'd0);

    // A byte is ready on the 8th sample, or on flush of a partial byte (left-justified, zero-padded).
    always_comb begin
        byteValid_c = (sampleEn && (bitCnt == 3'd7)) || (flush && pending_c);
        pixByte_c   = {shreg[BYTE_W-2:0], litBit};
        if (flush) begin
            pixByte_c = shreg << (4'd8 - 4'(bitCnt));
        end
    end

    // Shift register and bit counter; stale upper bits fall off during left-justification.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            shreg  <= '0;
            bitCnt <= 3'd0;
        end else if (clear || flush) begin
            shreg  <= '0;
            bitCnt <= 3'd0;
        end else if (sampleEn) begin
            shreg  <= {shreg[BYTE_W-2:0], litBit};
            bitCnt <= bitCnt + 3'd1;
        end
    end

endmodule

// File: rtl/dvi_frame_packer.sv
// Captures a thresholded, vertically decimated DVI frame into the byte-row-major frame RAM.
module dvi_frame_packer
    import dvi_el_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
    parameter int unsigned SCREEN_HEIGHT  = SCREEN_HEIGHT_DEF,
    parameter int unsigned LINE_DECIM     = 2,
    parameter int unsigned THRESHOLD      = 128,
    parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               de,
    input  logic               vsync,
    input  logic [BYTE_W-1:0]  luma,
    dvi_frame_packer_if.master ramIf,
    output logic               frame_done,
    output logic               sync_lost
);

    localparam int unsigned LCNT_W = $clog2(SCREEN_HEIGHT + 1);
    localparam int unsigned BX_W   = $clog2(SCREEN_WIDTH + 1);
    localparam int unsigned DEC_W  = (LINE_DECIM > 1) ? $clog2(LINE_DECIM) : 1;

    // The stored frame must fit the 15-bit RAM address space.
    if (SCREEN_WIDTH * SCREEN_HEIGHT > (1 << ADDR_W)) begin : gAddrCheck
        $error("dvi_frame_packer: SCREEN_WIDTH*SCREEN_HEIGHT exceeds the frame RAM");
    end
    if (LINE_DECIM < 1) begin : gDecimCheck
        $error("dvi_frame_packer: LINE_DECIM must be at least 1");
    end

    logic              deR;
    logic              dePrev;
    logic              vsR;
    logic              vsPrev;
    logic [BYTE_W-1:0] lumaR;

    fsmState_t         state;
    logic [LCNT_W-1:0] lineCnt;
    logic [DEC_W-1:0]  decimCnt;
    logic [BX_W-1:0]   byteX;
    logic [ADDR_W-1:0] lineBase;
    logic              lineStored;
    logic              pendDone;

    logic              vsEdge;
    logic              deRise;
    logic              deFall;
    logic              storeLine;
    logic              lastLine;
    logic              byteFits;
    logic              sampleEn;
    logic              packFlush;
    logic              packClear;
    logic              byteValid_c;
    logic [BYTE_W-1:0] pixByte_c;
    logic              pending_c;

    // Input stage: one register on every DVI input, vsync normalised to active-high.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            deR    <= 1'b0;
            dePrev <= 1'b0;
            vsR    <= 1'b0;
            vsPrev <= 1'b0;
            lumaR  <= '0;
        end else begin
            deR    <= de;
            dePrev <= deR;
            vsR    <= VS_ACTIVE_HIGH ? vsync : ~vsync;
            vsPrev <= vsR;
            lumaR  <= luma;
        end
    end

    // Edge detects and packer controls; an abort suppresses sampling and flushing.
    always_comb begin
        vsEdge    = vsR & ~vsPrev;
        deRise    = deR & ~dePrev;
        deFall    = ~deR & dePrev;
        storeLine = (decimCnt == '0) && (lineCnt < LCNT_W'(SCREEN_HEIGHT));
        lastLine  = (lineCnt == LCNT_W'(SCREEN_HEIGHT - 1));
        byteFits  = (byteX < BX_W'(SCREEN_WIDTH));
        sampleEn  = !vsEdge && (((state == IN_LINE) && deR) ||
                                ((state == WAIT_LINE) && deRise && storeLine));
        packFlush = !vsEdge && (state == FLUSH);
        packClear = vsEdge || (state == WAIT_VS) || (state == LINE_END);
    end

    pix_packer_8 #(
        .THRESHOLD (THRESHOLD)
    ) uPacker (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .sampleEn    (sampleEn),
        .flush       (packFlush),
        .clear       (packClear),
        .lumaIn      (lumaR),
        .byteValid_c (byteValid_c),
        .pixByte_c   (pixByte_c),
        .pending_c   (pending_c)
    );

    // Line FSM, counters, running line base and registered RAM write port.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_VS;
            lineCnt       <= '0;
            decimCnt      <= '0;
            byteX         <= '0;
            lineBase      <= '0;
            lineStored    <= 1'b0;
            pendDone      <= 1'b0;
            ramIf.wr_en   <= 1'b0;
            ramIf.wr_addr <= '0;
            ramIf.wr_data <= '0;
            frame_done    <= 1'b0;
            sync_lost     <= 1'b0;
        end else begin
            ramIf.wr_en <= 1'b0;
            frame_done  <= 1'b0;

            // Bytes past the stored line width are discarded.
            if (byteValid_c && byteFits) begin
                ramIf.wr_en   <= 1'b1;
                ramIf.wr_data <= pixByte_c;
                ramIf.wr_addr <= lineBase + ADDR_W'(byteX);
                byteX         <= byteX + BX_W'(1);
            end

            if (vsEdge) begin
                if (state != WAIT_VS) begin
                    sync_lost <= 1'b1;
                end
                state      <= WAIT_LINE;
                lineCnt    <= '0;
                decimCnt   <= '0;
                byteX      <= '0;
                lineBase   <= '0;
                lineStored <= 1'b0;
                pendDone   <= 1'b0;
            end else begin
                case (state)
                    WAIT_VS: begin
                    end
                    WAIT_LINE: begin
                        if (deRise) begin
                            lineStored <= storeLine;
                            state      <= storeLine ? IN_LINE : SKIP_LINE;
                        end
                    end
                    IN_LINE: begin
                        if (deFall) begin
                            if (pending_c) begin
                                state <= FLUSH;
                            end else begin
                                // Last write already went out this cycle, so signal completion now.
                                state <= LINE_END;
                                if (lastLine) begin
                                    frame_done <= 1'b1;
                                    sync_lost  <= 1'b0;
                                end
                            end
                        end
                    end
                    FLUSH: begin
                        state    <= LINE_END;
                        pendDone <= lastLine;
                    end
                    SKIP_LINE: begin
                        if (deFall) begin
                            state <= LINE_END;
                        end
                    end
                    LINE_END: begin
                        decimCnt <= (decimCnt == DEC_W'(LINE_DECIM - 1)) ? '0 : decimCnt + DEC_W'(1);
                        if (lineStored) begin
                            lineCnt  <= lineCnt + LCNT_W'(1);
                            byteX    <= '0;
                            lineBase <= lineBase + ADDR_W'(SCREEN_WIDTH);
                        end
                        if (pendDone) begin
                            frame_done <= 1'b1;
                            sync_lost  <= 1'b0;
                        end
                        pendDone <= 1'b0;
                        state    <= (lineStored && lastLine) ? WAIT_VS : WAIT_LINE;
                    end
                    default: begin
                        state <= WAIT_VS;
                    end
                endcase
            end
        end
    end

endmodule
